rs232_frame_rx: RTL and testbench
=================================

Name: rs232_frame_rx

Overview:
- Frame assembler sitting directly downstream of the RS-232 byte receiver; it consumes the received byte stream.
- Accepts framed packets of 8 bytes: STX 0x02, six payload bytes, ETX 0x03.
- Delivers the 48-bit payload to the AES/storage stage over a valid/ready handshake.
- Rejects malformed, truncated and overrun frames and reports each with an error code.

Parameters:
- PAYLOAD_BYTES, 6, number of payload bytes between STX and ETX.
- TIMEOUT_CYCLES, 1000, idle clocks allowed between bytes inside a frame (about 2 byte times at 45 clk/bit).

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous reset, active-low.
- in_valid  input  1  one-cycle strobe: in_data holds a received byte. No backpressure.
- in_data  input  8  received byte.
- out_valid  output  1  payload available.
- out_ready  input  1  consumer accepts the payload.
- out_data  output  48  payload; first payload byte in [47:40], last in [7:0].
- frame_err  output  1  one-cycle pulse when a frame is discarded.
- err_code  output  2  cause of the last discard: 0 none, 1 bad ETX, 2 timeout, 3 overrun. Holds until the next discard.
- busy  output  1  high while a frame is being assembled.

Behaviour:
- Reset (rst low, asynchronous): state IDLE; out_valid 0, out_data 0, frame_err 0, err_code 0, busy 0; byte and timeout counters 0.
- State IDLE:
  - in_valid with 0x02 -> PAYLOAD, byte count = 0.
  - Any other byte is ignored silently; no error is raised.
- State PAYLOAD:
  - Each in_valid shifts in_data into a 48-bit shift register, MSB first, and increments the count.
  - After PAYLOAD_BYTES bytes -> ETX_WAIT.
  - 0x02 and 0x03 are legal payload values here.
- State ETX_WAIT:
  - in_valid with 0x03 -> frame complete, go to IDLE.
  - Any other byte -> discard, err_code 1, go to IDLE.
- Frame completion:
  - If out_valid is 0, or out_valid=1 with out_ready=1 in the same cycle: load out_data from the shift register and set out_valid the next cycle.
  - Latency is 1 clock from the ETX strobe to out_valid.
  - If out_valid=1 and out_ready=0: drop the new frame, err_code 3, out_data unchanged.
- Handshake:
  - Transfer occurs when out_valid and out_ready are both high; out_valid clears the next cycle unless a new frame completes in that same cycle.
  - out_data is stable while out_valid=1 and no transfer occurs.
- busy = (state != IDLE).
- frame_err is a single-cycle pulse, registered; err_code updates in the same cycle.
- Frames continue to be assembled while out_valid is held high.
- Counter width is $clog2(PAYLOAD_BYTES+1). The timeout counter is $clog2(TIMEOUT_CYCLES) bits and saturates; it never wraps.

Optional Feature:
- Macro: RS232_FRAME_TIMEOUT_EN.
- Defined:
  - In PAYLOAD or ETX_WAIT, the timeout counter increments each cycle without in_valid and clears on in_valid or state entry.
  - On reaching TIMEOUT_CYCLES-1: abort to IDLE, frame_err pulse, err_code 2.
  - If in_valid arrives on the expiry cycle, the byte wins and the counter clears.
- Undefined:
  - No counter is present; a frame waits indefinitely.
  - A dropped byte surfaces as a bad-ETX error on a later byte.

Decomposition:
- Package rs232_pkg:
  - STX_BYTE = 8'h02, ETX_BYTE = 8'h03.
  - Enum frame_state_t {IDLE, PAYLOAD, ETX_WAIT}.
  - Enum err_code_t {ERR_NONE, ERR_ETX, ERR_TIMEOUT, ERR_OVERRUN}.
- Sub-module: rs232_frame_timeout, the timeout counter with clear, run and expire signals. It is instantiated only under RS232_FRAME_TIMEOUT_EN.

Test Plan:
- Single byte 0x40, then idle -> no state change, busy 0, frame_err 0.
- Bytes 02 FF F0 55 AA 3C C3 03 with out_ready=1 -> out_valid for 1 cycle, 1 clk after ETX, out_data=48'hFFF055AA3CC3.
- Bytes 02 FF F0 55 AA 3C C3 C0 -> frame_err pulse, err_code=1, out_valid stays 0; next good frame is delivered correctly.
- Dropped byte: 02 FF F0 55 3C C3 0F, then a gap of more than TIMEOUT_CYCLES, then 03:
  - With RS232_FRAME_TIMEOUT_EN: err_code=2 at expiry; the trailing 03 is ignored in IDLE.
  - Without it: 03 lands in ETX_WAIT and is accepted; out_data=48'hFFF0553CC30F.
- Two good frames back-to-back with out_ready=0 -> first frame is held, second is dropped, err_code=3; raising out_ready returns the first payload.
- Assert rst low mid-PAYLOAD (after 3 bytes) -> all outputs 0 immediately; bytes arriving after release without STX are ignored.

Source files
------------

// File: rtl/rs232_pkg.sv
// Shared constants and enums for the RS-232 frame assembler.
package rs232_pkg;

  localparam logic [7:0] STX_BYTE = 8'h02;
  localparam logic [7:0] ETX_BYTE = 8'h03;

  typedef enum logic [1:0] {
    IDLE,
    PAYLOAD,
    ETX_WAIT
  } frame_state_t;

  typedef enum logic [1:0] {
    ERR_NONE,
    ERR_ETX,
    ERR_TIMEOUT,
    ERR_OVERRUN
  } err_code_t;

endpackage

// File: rtl/rs232_frame_timeout.sv
// Inter-byte idle counter for the frame assembler; saturates at TIMEOUT_CYCLES-1
// and flags expiry there. Used only when RS232_FRAME_TIMEOUT_EN is defined.
module rs232_frame_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clear,
  input  logic i_run,
  output logic o_expire_c
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_run && (r_cnt != LAST)) begin
      r_cnt <= r_cnt + TW'(1);
    end
  end

  assign o_expire_c = (r_cnt == LAST);

endmodule

// File: rtl/rs232_frame_rx.sv
// Assembles STX / payload / ETX frames from the byte receiver and hands the
// payload downstream over valid/ready. Optional timeout: RS232_FRAME_TIMEOUT_EN.
module rs232_frame_rx
  import rs232_pkg::*;
#(
  parameter int unsigned PAYLOAD_BYTES  = 6,
  parameter int unsigned TIMEOUT_CYCLES = 1000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic [7:0]                 in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [8*PAYLOAD_BYTES-1:0] out_data,
  output logic                       frame_err,
  output logic [1:0]                 err_code,
  output logic                       busy
);

  localparam int unsigned PW = 8 * PAYLOAD_BYTES;
  localparam int unsigned CW = $clog2(PAYLOAD_BYTES + 1);

  frame_state_t  r_state;
  logic [CW-1:0] r_cnt;
  logic [PW-1:0] r_shift;
  logic [PW-1:0] r_out_data;
  logic          r_out_valid;
  logic          r_frame_err;
  err_code_t     r_err_code;
  logic          r_busy;
  logic          w_expire;

`ifdef RS232_FRAME_TIMEOUT_EN
  logic w_tmo_clear;
  logic w_tmo_run;

  // Counter restarts on every byte and is held at zero outside a frame.
  assign w_tmo_clear = in_valid || (r_state == IDLE);
  assign w_tmo_run   = !w_tmo_clear;

  rs232_frame_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk        (clk),
    .rst        (rst),
    .i_clear    (w_tmo_clear),
    .i_run      (w_tmo_run),
    .o_expire_c (w_expire)
  );
`else
  // No timeout: an incomplete frame waits indefinitely.
  assign w_expire = 1'b0 & (TIMEOUT_CYCLES != 0);
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_shift     <= '0;
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_frame_err <= 1'b0;
      r_err_code  <= ERR_NONE;
      r_busy      <= 1'b0;
    end else begin
      r_frame_err <= 1'b0;
      if (r_out_valid && out_ready) begin
        r_out_valid <= 1'b0;
      end
      case (r_state)
        IDLE: begin
          if (in_valid && (in_data == STX_BYTE)) begin
            r_state <= PAYLOAD;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
          end
        end
        PAYLOAD: begin
          if (in_valid) begin
            r_shift <= PW'({r_shift, in_data});
            r_cnt   <= r_cnt + CW'(1);
            if (r_cnt == CW'(PAYLOAD_BYTES - 1)) begin
              r_state <= ETX_WAIT;
            end
          end else if (w_expire) begin
            r_state     <= IDLE;
            r_busy      <= 1'b0;
            r_frame_err <= 1'b1;
            r_err_code  <= ERR_TIMEOUT;
          end
        end
        ETX_WAIT: begin
          if (in_valid) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            if (in_data != ETX_BYTE) begin
              r_frame_err <= 1'b1;
              r_err_code  <= ERR_ETX;
            end else if (!r_out_valid || out_ready) begin
              // A same-cycle transfer frees the output slot for the new frame.
              r_out_data  <= r_shift;
              r_out_valid <= 1'b1;
            end else begin
              r_frame_err <= 1'b1;
              r_err_code  <= ERR_OVERRUN;
            end
          end else if (w_expire) begin
            r_state     <= IDLE;
            r_busy      <= 1'b0;
            r_frame_err <= 1'b1;
            r_err_code  <= ERR_TIMEOUT;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign frame_err = r_frame_err;
  assign err_code  = r_err_code;
  assign busy      = r_busy;

endmodule

// File: tb/tb_rs232_frame_rx.sv
// Directed bench for rs232_frame_rx: per-cycle vector table plus hand-written
// sequences for the inter-byte gap and mid-frame reset.
module tb_rs232_frame_rx;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        out_ready = 1'b1;
  logic        out_valid;
  logic [47:0] out_data;
  logic        frame_err;
  logic [1:0]  err_code;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;
  int abort_at;
  int n_fe;

  always #5 clk = ~clk;

  rs232_frame_rx dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .frame_err (frame_err),
    .err_code  (err_code),
    .busy      (busy)
  );

  typedef struct {
    logic        vld;
    logic [7:0]  d;
    logic        rdy;
    logic        ov;
    logic        fe;
    logic [1:0]  ec;
    logic        by;
    logic        cd;
    logic [47:0] dat;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // One clock: drive at negedge, sample 1 time unit after the posedge.
  task automatic cyc(input logic v, input logic [7:0] d, input logic r);
    @(negedge clk);
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  function automatic vec_t mk(input logic vld, input logic [7:0] d, input logic rdy,
                              input logic ov, input logic fe, input logic [1:0] ec,
                              input logic by, input logic cd, input logic [47:0] dat);
    vec_t v;
    v.vld = vld; v.d = d; v.rdy = rdy; v.ov = ov; v.fe = fe;
    v.ec = ec; v.by = by; v.cd = cd; v.dat = dat;
    return v;
  endfunction

  // STX plus six payload bytes; the output side is expected to hold ov/dat.
  task automatic add_payload(input logic [47:0] p, input logic rdy, input logic ov,
                             input logic [1:0] ec, input logic [47:0] dat);
    vecs.push_back(mk(1'b1, 8'h02, rdy, ov, 1'b0, ec, 1'b1, ov, dat));
    for (int i = 0; i < 6; i++)
      vecs.push_back(mk(1'b1, p[47-8*i -: 8], rdy, ov, 1'b0, ec, 1'b1, ov, dat));
  endtask

  task automatic send_payload(input logic [47:0] p, input logic r);
    cyc(1'b1, 8'h02, r);
    for (int i = 0; i < 6; i++) cyc(1'b1, p[47-8*i -: 8], r);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ov",   64'(out_valid), 64'd0);
    chk("rst_data", 64'(out_data),  64'd0);
    chk("rst_fe",   64'(frame_err), 64'd0);
    chk("rst_ec",   64'(err_code),  64'd0);
    chk("rst_busy", 64'(busy),      64'd0);
    @(negedge clk);
    rst = 1'b1;

    // Stray byte in IDLE, then idle
    vecs.push_back(mk(1'b1, 8'h40, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 48'h0));
    vecs.push_back(mk(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 48'h0));
    // Good frame, consumer ready
    add_payload(48'hFFF055AA3CC3, 1'b1, 1'b0, 2'd0, 48'h0);
    vecs.push_back(mk(1'b1, 8'h03, 1'b1, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 48'hFFF055AA3CC3));
    vecs.push_back(mk(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 48'hFFF055AA3CC3));
    // Bad ETX
    add_payload(48'hFFF055AA3CC3, 1'b1, 1'b0, 2'd0, 48'h0);
    vecs.push_back(mk(1'b1, 8'hC0, 1'b1, 1'b0, 1'b1, 2'd1, 1'b0, 1'b0, 48'h0));
    vecs.push_back(mk(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0, 48'h0));
    // Recovery frame with STX/ETX values inside the payload
    add_payload(48'h020355AA0302, 1'b1, 1'b0, 2'd1, 48'h0);
    vecs.push_back(mk(1'b1, 8'h03, 1'b1, 1'b1, 1'b0, 2'd1, 1'b0, 1'b1, 48'h020355AA0302));
    vecs.push_back(mk(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 2'd1, 1'b0, 1'b1, 48'h020355AA0302));
    // Overrun: first frame held, second dropped
    add_payload(48'hA1A2A3A4A5A6, 1'b0, 1'b0, 2'd1, 48'h0);
    vecs.push_back(mk(1'b1, 8'h03, 1'b0, 1'b1, 1'b0, 2'd1, 1'b0, 1'b1, 48'hA1A2A3A4A5A6));
    add_payload(48'hB1B2B3B4B5B6, 1'b0, 1'b1, 2'd1, 48'hA1A2A3A4A5A6);
    vecs.push_back(mk(1'b1, 8'h03, 1'b0, 1'b1, 1'b1, 2'd3, 1'b0, 1'b1, 48'hA1A2A3A4A5A6));
    vecs.push_back(mk(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 2'd3, 1'b0, 1'b1, 48'hA1A2A3A4A5A6));
    vecs.push_back(mk(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 2'd3, 1'b0, 1'b1, 48'hA1A2A3A4A5A6));
    // Completion in the same cycle as a transfer reloads the output
    add_payload(48'hC1C2C3C4C5C6, 1'b0, 1'b0, 2'd3, 48'h0);
    vecs.push_back(mk(1'b1, 8'h03, 1'b0, 1'b1, 1'b0, 2'd3, 1'b0, 1'b1, 48'hC1C2C3C4C5C6));
    add_payload(48'hD1D2D3D4D5D6, 1'b0, 1'b1, 2'd3, 48'hC1C2C3C4C5C6);
    vecs.push_back(mk(1'b1, 8'h03, 1'b1, 1'b1, 1'b0, 2'd3, 1'b0, 1'b1, 48'hD1D2D3D4D5D6));
    vecs.push_back(mk(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 2'd3, 1'b0, 1'b1, 48'hD1D2D3D4D5D6));

    foreach (vecs[i]) begin
      cyc(vecs[i].vld, vecs[i].d, vecs[i].rdy);
      chk($sformatf("vec%0d_ov", i),   64'(out_valid), 64'(vecs[i].ov));
      chk($sformatf("vec%0d_fe", i),   64'(frame_err), 64'(vecs[i].fe));
      chk($sformatf("vec%0d_ec", i),   64'(err_code),  64'(vecs[i].ec));
      chk($sformatf("vec%0d_busy", i), 64'(busy),      64'(vecs[i].by));
      if (vecs[i].cd) chk($sformatf("vec%0d_data", i), 64'(out_data), 64'(vecs[i].dat));
    end

    // Dropped byte followed by a long gap
    send_payload(48'hFFF0553CC30F, 1'b1);
    chk("gap_busy_start", 64'(busy), 64'd1);
`ifdef RS232_FRAME_TIMEOUT_EN
    abort_at = -1;
    for (int k = 1; k <= 1100 && abort_at < 0; k++) begin
      cyc(1'b0, 8'h00, 1'b1);
      if (frame_err) abort_at = k;
    end
    chk("tmo_cycle", 64'(abort_at), 64'd1000);
    chk("tmo_ec",    64'(err_code), 64'd2);
    chk("tmo_busy",  64'(busy),     64'd0);
    cyc(1'b1, 8'h03, 1'b1);
    chk("tmo_etx_ov",   64'(out_valid), 64'd0);
    chk("tmo_etx_fe",   64'(frame_err), 64'd0);
    chk("tmo_etx_busy", 64'(busy),      64'd0);
    chk("tmo_etx_ec",   64'(err_code),  64'd2);
`else
    n_fe = 0;
    repeat (1100) begin
      cyc(1'b0, 8'h00, 1'b1);
      if (frame_err) n_fe++;
    end
    chk("gap_no_err",  64'(n_fe), 64'd0);
    chk("gap_busy",    64'(busy), 64'd1);
    cyc(1'b1, 8'h03, 1'b1);
    chk("gap_etx_ov",   64'(out_valid), 64'd1);
    chk("gap_etx_data", 64'(out_data),  64'hFFF0553CC30F);
    chk("gap_etx_fe",   64'(frame_err), 64'd0);
`endif
    cyc(1'b0, 8'h00, 1'b1);

    // Reset in the middle of a frame while a payload is held
    send_payload(48'h5A5A5A5A5A5A, 1'b0);
    cyc(1'b1, 8'h03, 1'b0);
    chk("pre_rst_ov", 64'(out_valid), 64'd1);
    cyc(1'b1, 8'h02, 1'b0);
    cyc(1'b1, 8'h11, 1'b0);
    cyc(1'b1, 8'h22, 1'b0);
    cyc(1'b1, 8'h33, 1'b0);
    chk("pre_rst_busy", 64'(busy), 64'd1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mid_rst_ov",   64'(out_valid), 64'd0);
    chk("mid_rst_data", 64'(out_data),  64'd0);
    chk("mid_rst_fe",   64'(frame_err), 64'd0);
    chk("mid_rst_ec",   64'(err_code),  64'd0);
    chk("mid_rst_busy", 64'(busy),      64'd0);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 7; i++) begin
      cyc(1'b1, (i == 6) ? 8'h03 : 8'(8'h44 + i), 1'b1);
      chk($sformatf("post_rst%0d_busy", i), 64'(busy),      64'd0);
      chk($sformatf("post_rst%0d_ov", i),   64'(out_valid), 64'd0);
    end
    send_payload(48'h123456789ABC, 1'b1);
    cyc(1'b1, 8'h03, 1'b1);
    chk("final_ov",   64'(out_valid), 64'd1);
    chk("final_data", 64'(out_data),  64'h123456789ABC);
    cyc(1'b0, 8'h00, 1'b1);
    chk("final_drain", 64'(out_valid), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
